// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if -- SRAM-like instruction bus between the fetch stage and memory.
//
// Signals:
//   inst_req      fetch -> mem  request valid
//   inst_addr     fetch -> mem  request address (sampled only with inst_addr_ok)
//   inst_addr_ok  mem -> fetch  request accepted this cycle
//   inst_data_ok  mem -> fetch  read data valid this cycle
//   inst_rdata    mem -> fetch  read data
//
// Modports: master (fetch stage), slave (memory side).
// ---------------------------------------------------------------------------
interface if_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the fetch PC, drives the instruction bus (one outstanding request),
// applies ID-stage branch redirects and exception/ERET flush redirects,
// discards stale responses after a flush and requests a stall while no
// instruction is available.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cu_stall          IF/ID holding, do not hand off
//   cu_flush/flush_pc flush redirect and its target
//   br_taken/br_target branch redirect from ID (applied at delay-slot handoff)
//   ibus              instruction bus (if_fetch_if.master)
//   pc, pc_4          PC of presented instruction and PC+4 (mod 2^32)
//   instr             presented instruction
//   if_excepttype     exception vector of the presented instruction
//   fetch_stall_req   high when no instruction is available this cycle
//
// Build option: define IF_ADEL_CHECK_EN to raise AdEL on misaligned fetch
// addresses instead of issuing the request.
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cu_stall,
    input  logic              cu_flush,
    input  logic [31:0]       flush_pc,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    if_fetch_if.master        ibus,
    output logic [31:0]       pc,
    output logic [31:0]       pc_4,
    output logic [31:0]       instr,
    output logic [31:0]       if_excepttype,
    output logic              fetch_stall_req
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    logic [31:0] fpc;
    logic [31:0] buf_instr;
    logic [31:0] buf_exc;

    logic adel;       // misaligned fetch detected in REQ
    logic data_hit;   // live response arriving this cycle
    logic avail;
    logic handoff;
    logic req_int;
    logic req_fire;

`ifdef IF_ADEL_CHECK_EN
    assign adel           = (state == S_REQ) && (fpc[1:0] != 2'b00);
    assign ibus.inst_addr = fpc;
`else
    assign adel           = 1'b0;
    assign ibus.inst_addr = {fpc[31:2], 2'b00};
`endif

    assign data_hit = (state == S_WAIT) && ibus.inst_data_ok;
    assign avail    = data_hit || (state == S_HOLD) || adel;
    assign handoff  = avail && !cu_stall && !cu_flush;
    assign req_int  = (state == S_REQ) && !adel;
    assign req_fire = req_int && ibus.inst_addr_ok;

    assign ibus.inst_req   = !reset && req_int;
    assign fetch_stall_req = reset || !avail;
    assign pc              = reset ? RESET_PC : fpc;
    assign pc_4            = pc + 32'd4;

    always_comb begin
        instr         = buf_instr;
        if_excepttype = 32'h0;
        if (reset) begin
            instr = 32'h0;
        end else if (adel) begin
            instr         = 32'h0;
            if_excepttype = 32'h0000_0010;
        end else if (data_hit) begin
            instr = ibus.inst_rdata;
        end else if (state == S_HOLD) begin
            if_excepttype = buf_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc       <= RESET_PC;
            state     <= S_REQ;
            buf_instr <= 32'h0;
            buf_exc   <= 32'h0;
        end else begin
            // Flush wins over handoff; a taken branch in ID redirects the
            // fetch after the delay slot is handed off.
            if (cu_flush)
                fpc <= flush_pc;
            else if (handoff)
                fpc <= br_taken ? br_target : fpc + 32'd4;

            case (state)
                S_REQ: begin
                    // An accepted request under flush leaves a stale response
                    // in flight that must be swallowed.
                    if (cu_flush)
                        state <= req_fire ? S_DROP : S_REQ;
                    else if (req_fire)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ibus.inst_data_ok) begin
                        if (cu_flush || !cu_stall) begin
                            state <= S_REQ;
                        end else begin
                            state     <= S_HOLD;
                            buf_instr <= ibus.inst_rdata;
                            buf_exc   <= 32'h0;
                        end
                    end else if (cu_flush) begin
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (cu_flush || handoff)
                        state <= S_REQ;
                end
                S_DROP: begin
                    // A flush here only retargets fpc; the in-flight
                    // response is still the one being discarded.
                    if (ibus.inst_data_ok)
                        state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
    localparam logic [31:0] B = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cu_stall = 1'b0, cu_flush = 1'b0, br_taken = 1'b0;
    logic [31:0] flush_pc = '0, br_target = '0;
    logic [31:0] pc, pc_4, instr, if_excepttype;
    logic        fetch_stall_req;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(B)) dut (
        .clk(clk), .reset(reset), .cu_stall(cu_stall), .cu_flush(cu_flush),
        .flush_pc(flush_pc), .br_taken(br_taken), .br_target(br_target),
        .ibus(bus), .pc(pc), .pc_4(pc_4), .instr(instr),
        .if_excepttype(if_excepttype), .fetch_stall_req(fetch_stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, fl;
        logic [31:0] fp;
        logic        br;
        logic [31:0] bt;
        logic        aok, dok;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic [31:0] e_pc, e_instr, e_exc;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic fl, input logic [31:0] fp,
        input logic br, input logic [31:0] bt, input logic aok, input logic dok,
        input logic [31:0] rd, input logic er, input logic [31:0] ea,
        input logic es, input logic [31:0] ep, input logic [31:0] ei,
        input logic [31:0] ee);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.fp = fp; v.br = br; v.bt = bt;
        v.aok = aok; v.dok = dok; v.rd = rd; v.e_req = er; v.e_addr = ea;
        v.e_stall = es; v.e_pc = ep; v.e_instr = ei; v.e_exc = ee;
        return v;
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic        outst;
        int          cnt;
        int          n_hand;
        logic [31:0] lat, mpc, e;

        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;

        //        rst stl fl flush_pc  br br_target     aok dok rdata          | req addr          stall pc            instr          exc
        tbl.push_back(mk(1,0,0,0,        0,0,            0,0,0,             0,0,            1,B,            0,             0));
        tbl.push_back(mk(1,0,0,0,        0,0,            0,0,0,             0,0,            1,B,            0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B,            1,B,            0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,1,32'h2408_0001, 0,0,            0,B,            32'h2408_0001, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+4,          1,B+4,          0,             0));
        tbl.push_back(mk(0,1,0,0,        0,0,            0,1,32'h1111_1111, 0,0,            0,B+4,          32'h1111_1111, 0));
        tbl.push_back(mk(0,1,0,0,        0,0,            0,0,0,             0,0,            0,B+4,          32'h1111_1111, 0));
        tbl.push_back(mk(0,1,0,0,        0,0,            0,0,0,             0,0,            0,B+4,          32'h1111_1111, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,0,0,             0,0,            0,B+4,          32'h1111_1111, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+8,          1,B+8,          0,             0));
        tbl.push_back(mk(0,0,0,0,        1,B+32'h100,    0,1,32'h1000_0010, 0,0,            0,B+8,          32'h1000_0010, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+32'h100,    1,B+32'h100,    0,             0));
        tbl.push_back(mk(0,0,1,B+32'h380,0,0,            0,0,0,             0,0,            1,B+32'h100,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,0,0,             0,0,            1,B+32'h380,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,1,32'hDEAD_BEEF, 0,0,            1,B+32'h380,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+32'h380,    1,B+32'h380,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,1,32'h2222_2222, 0,0,            0,B+32'h380,    32'h2222_2222, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,0,0,             1,B+32'h384,    1,B+32'h384,    0,             0));
        tbl.push_back(mk(0,0,1,B+32'h200,0,0,            0,0,0,             1,B+32'h384,    1,B+32'h384,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+32'h200,    1,B+32'h200,    0,             0));
        tbl.push_back(mk(0,0,1,B+32'h300,0,0,            0,1,32'h3333_3333, 0,0,            0,B+32'h200,    32'h3333_3333, 0));
        tbl.push_back(mk(0,0,1,B+32'h400,0,0,            1,0,0,             1,B+32'h300,    1,B+32'h300,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,1,32'hBADB_AD00, 0,0,            1,B+32'h400,    0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+32'h400,    1,B+32'h400,    0,             0));
        tbl.push_back(mk(0,1,0,0,        0,0,            0,1,32'h4444_4444, 0,0,            0,B+32'h400,    32'h4444_4444, 0));
        tbl.push_back(mk(0,0,1,B+32'h500,0,0,            0,0,0,             0,0,            0,B+32'h400,    32'h4444_4444, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,B+32'h500,    1,B+32'h500,    0,             0));
        tbl.push_back(mk(0,0,0,0,        1,32'hFFFF_FFFC,0,1,32'h5555_5555, 0,0,            0,B+32'h500,    32'h5555_5555, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,             0));
        tbl.push_back(mk(0,0,0,0,        0,0,            0,1,32'h6666_6666, 0,0,            0,32'hFFFF_FFFC,32'h6666_6666, 0));
        tbl.push_back(mk(0,0,0,0,        0,0,            1,0,0,             1,0,            1,0,            0,             0));
        tbl.push_back(mk(0,0,0,0,        1,B+32'h102,    0,1,32'h7777_7777, 0,0,            0,0,            32'h7777_7777, 0));
`ifdef IF_ADEL_CHECK_EN
        tbl.push_back(mk(0,1,0,0,        0,0,            0,0,0,             0,0,            0,B+32'h102,    0,             32'h10));
        tbl.push_back(mk(0,0,1,B+32'h380,0,0,            0,0,0,             0,0,            0,B+32'h102,    0,             32'h10));
`else
        tbl.push_back(mk(0,1,0,0,        0,0,            0,0,0,             1,B+32'h100,    1,B+32'h102,    0,             0));
        tbl.push_back(mk(0,0,1,B+32'h380,0,0,            0,0,0,             1,B+32'h100,    1,B+32'h102,    0,             0));
`endif
        tbl.push_back(mk(0,0,0,0,        0,0,            0,0,0,             1,B+32'h380,    1,B+32'h380,    0,             0));

        foreach (tbl[i]) begin
            @(negedge clk);
            reset            = tbl[i].rst;
            cu_stall         = tbl[i].stl;
            cu_flush         = tbl[i].fl;
            flush_pc         = tbl[i].fp;
            br_taken         = tbl[i].br;
            br_target        = tbl[i].bt;
            bus.inst_addr_ok = tbl[i].aok;
            bus.inst_data_ok = tbl[i].dok;
            bus.inst_rdata   = tbl[i].rd;
            #1;
            chk($sformatf("row%0d_req", i),   32'(bus.inst_req),        32'(tbl[i].e_req));
            chk($sformatf("row%0d_stall", i), 32'(fetch_stall_req),     32'(tbl[i].e_stall));
            chk($sformatf("row%0d_pc", i),    pc,                       tbl[i].e_pc);
            chk($sformatf("row%0d_pc4", i),   pc_4,                     tbl[i].e_pc + 32'd4);
            chk($sformatf("row%0d_exc", i),   if_excepttype,            tbl[i].e_exc);
            if (tbl[i].e_req)
                chk($sformatf("row%0d_addr", i), bus.inst_addr, tbl[i].e_addr);
            if (!tbl[i].e_stall || tbl[i].rst)
                chk($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
        end

        // Random-latency bus with random IF/ID stalls; scoreboard holds the
        // expected fetch PCs in order of acceptance.
        cu_flush = 1'b0; br_taken = 1'b0;
        outst = 1'b0; cnt = 0; n_hand = 0; lat = '0;
        mpc = B + 32'h380;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            cu_stall         = ($urandom_range(0, 2) == 0);
            bus.inst_data_ok = outst && (cnt == 0);
            bus.inst_rdata   = bus.inst_data_ok ? mem(lat) : 32'h0;
            if (outst && cnt > 0) cnt--;
            bus.inst_addr_ok = bus.inst_req && !outst && ($urandom_range(0, 3) != 0);
            #1;
            if (bus.inst_addr_ok) begin
                chk("rnd_addr", bus.inst_addr, mpc);
                sb.push_back(mpc);
                lat   = bus.inst_addr;
                mpc   = mpc + 32'd4;
                outst = 1'b1;
                cnt   = $urandom_range(0, 2);
            end
            if (!fetch_stall_req && !cu_stall) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rnd_sb_empty: handoff at pc %h with no request outstanding", pc);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_pc", pc, e);
                    chk("rnd_pc4", pc_4, e + 32'd4);
                    chk("rnd_instr", instr, mem(e));
                    chk("rnd_exc", if_excepttype, 32'h0);
                    n_hand++;
                end
            end
            if (bus.inst_data_ok) outst = 1'b0;
        end
        chk("rnd_handoffs_ge50", 32'(n_hand >= 50), 32'd1);
        chk("rnd_sb_leftover_le1", 32'(sb.size() <= 1), 32'd1);

        // Reset mid-stream returns to the reset presentation.
        @(negedge clk);
        reset = 1'b1; bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
        #1;
        chk("rst2_req", 32'(bus.inst_req), 32'd0);
        chk("rst2_stall", 32'(fetch_stall_req), 32'd1);
        chk("rst2_pc", pc, B);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_addr", bus.inst_addr, B);
        chk("rst2_req_after", 32'(bus.inst_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register and feeds it `pc`, `pc_4`, `instr` and `if_excepttype`. Owns the fetch PC and drives an SRAM-like instruction bus with a `req`/`addr_ok`/`data_ok` handshake and at most one outstanding request. Also applies ID-stage branch redirects and exception/ERET flush redirects, discards stale responses, and requests a pipeline stall while no instruction is available.

## Interface
- `RESET_PC`, default 32'hBFC0_0000, fetch address after reset.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cu_stall`  in  1  IF/ID holding; do not hand off.
- `cu_flush`  in  1  exception/ERET flush; redirect to `flush_pc`.
- `flush_pc`  in  32  flush redirect target.
- `br_taken`  in  1  branch in ID taken; valid while that branch is in ID.
- `br_target`  in  32  branch target.
- `inst_req`  out  1  bus request valid.
- `inst_addr`  out  32  bus request address.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `pc`  out  32  PC of the presented instruction.
- `pc_4`  out  32  `pc`+4, wraps modulo 2^32.
- `instr`  out  32  presented instruction.
- `if_excepttype`  out  32  exception vector for the presented instruction.
- `fetch_stall_req`  out  1  high when no instruction is available this cycle.

## Operation
- Registers: `fpc` (32), `state` (REQ, WAIT, HOLD, DROP), `buf_instr` (32), `buf_exc` (32).
- REQ: `inst_req`=1, `inst_addr`=`fpc`. On `inst_addr_ok`, go to WAIT.
- WAIT: on `inst_data_ok`, the instruction is available. If it is handed off, go to REQ; otherwise capture it into `buf_instr` and go to HOLD.
- HOLD: the instruction comes from `buf_instr`. Go to REQ once it is handed off.
- DROP: discard the next `inst_data_ok`, then go to REQ.
- Available means one of: WAIT with `inst_data_ok`, HOLD, or an AdEL fetch in REQ.
- `instr` is `inst_rdata` in WAIT with `inst_data_ok`, otherwise `buf_instr`. It is 0 on AdEL.
- `pc` is always `fpc`. `fetch_stall_req` is the inverse of available.
- Handoff occurs when the instruction is available and both `cu_stall`=0 and `cu_flush`=0. On handoff, `fpc` becomes `br_taken ? br_target : fpc+4`; this realises the delay slot.
- Flush has priority over handoff and sets `fpc` to `flush_pc`. Next state on flush:
  - REQ without `addr_ok`: REQ (the address changes next cycle).
  - REQ with `addr_ok`: DROP.
  - WAIT without `data_ok`: DROP.
  - WAIT with `data_ok`: REQ.
  - HOLD: REQ.
  - DROP: stays DROP.
- In DROP, `fetch_stall_req`=1 and `inst_req`=0. A second flush in DROP only updates `fpc`.
- The instruction bus shares `reset`, so no response survives a reset.

## Timing
- Reset values: `fpc`=`RESET_PC`, state=REQ, `buf_instr`=0, `buf_exc`=0.
- While `reset` is high: `inst_req`=0, `instr`=0, `if_excepttype`=0, `fetch_stall_req`=1, `pc`=`RESET_PC`, `pc_4`=`RESET_PC`+4.
- Zero-wait memory: `addr_ok` arrives in the REQ cycle N and `data_ok` in cycle N+1. Handoff happens in N+1 and the next REQ starts in N+2. Throughput is 1 instruction per 2 cycles.
- The redirect from `br_taken`/`flush_pc` takes effect on the `inst_addr` of the cycle after it is sampled.
- `inst_addr` is sampled by the bus only together with `inst_addr_ok`.

## Configuration
- `IF_ADEL_CHECK_EN` defined: in REQ with `fpc[1:0]`≠0, no bus request is issued (`inst_req`=0). The instruction is available immediately with `instr`=0 and `if_excepttype`=32'h0000_0010, and the normal handoff/flush rules apply. In all other cases `if_excepttype`=0.
- `IF_ADEL_CHECK_EN` undefined: no check is made. `inst_addr`={`fpc[31:2]`,2'b00} and `if_excepttype` is always 0.

## Test plan
- Reset release, zero-wait memory returning 32'h2408_0001 at 32'hBFC0_0000: `inst_addr`=BFC0_0000 in cycle 1, then handoff with `pc`=BFC0_0000, `pc_4`=BFC0_0004; next `inst_addr`=BFC0_0004.
- `cu_stall`=1 for 3 cycles when `data_ok` arrives: state HOLD, `instr` stable, `fetch_stall_req`=0, no new `inst_req`; handoff occurs in the first cycle with `cu_stall`=0.
- `br_taken`=1 with `br_target`=BFC0_0100 during the delay-slot handoff at BFC0_0008: next `inst_addr`=BFC0_0100.
- `cu_flush` with `flush_pc`=BFC0_0380 while in WAIT; the stale `data_ok` arrives 2 cycles later: it is dropped, `fetch_stall_req`=1, and the next `inst_addr`=BFC0_0380.
- With `IF_ADEL_CHECK_EN`, branch to BFC0_0102: no `inst_req`, `instr`=0, `if_excepttype`=32'h10, `pc`=BFC0_0102; a subsequent flush to BFC0_0380 resumes fetch.
